// File: rtl/block_a_atom_select.sv
`default_nettype none
// ============================================================================
// Module      : block_a_atom_select
// Description : OMP stage A. Correlates the residual r with every Phi atom
//               and selects lambda = argmax |<phi_j, r>| over the atoms that
//               have not been chosen yet. The selected-atom mask is kept
//               across searches until sel_clr or reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous active-high reset
//   start_a     in   1    pulse: begin a search (honoured only when idle)
//   sel_clr     in   1    pulse: clear the selected-atom mask
//   phi_addr    out  9    Phi BRAM address {atom, word}
//   phi_data    in   96   Phi BRAM read data (1-cycle latency)
//   r_addr      out  3    residual BRAM word address
//   r_data      in   96   residual BRAM read data (1-cycle latency)
//   busy_a      out  1    search in progress
//   done_a      out  1    pulse: found/lambda_out valid
//   found       out  1    an unselected atom existed
//   lambda_out  out  6    selected atom index
//   max_corr    out  56   |corr| of selected atom (only with the macro below)
// Configuration
//   BLOCK_A_CORR_OUT_EN : when defined, adds the max_corr output port.
// ============================================================================
module block_a_atom_select #(
  parameter int N_ATOMS = 64,
  parameter int WORDS   = 8,
  parameter int LANES   = 4,
  parameter int DW      = 24,
  parameter int ACC_W   = 56,
  parameter int ATOM_W  = $clog2(N_ATOMS),
  parameter int WORD_W  = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_a,
  input  logic                     sel_clr,
  output logic [ATOM_W+WORD_W-1:0] phi_addr,
  input  logic [LANES*DW-1:0]      phi_data,
  output logic [WORD_W-1:0]        r_addr,
  input  logic [LANES*DW-1:0]      r_data,
  output logic                     busy_a,
  output logic                     done_a,
  output logic                     found,
`ifdef BLOCK_A_CORR_OUT_EN
  output logic [ACC_W-1:0]         max_corr,
`endif
  output logic [ATOM_W-1:0]        lambda_out
);

  localparam int                ADDR_W      = ATOM_W + WORD_W;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;
  localparam logic [WORD_W-1:0] C_LAST_WORD = WORD_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_cnt;       // {atom, word} issue counter
  logic                r_v1;        // address issued last cycle -> data valid now
  logic [ADDR_W-1:0]   r_tag1;      // which {atom, word} the current data belongs to
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_max;
  logic                r_found;
  logic [ATOM_W-1:0]   r_lambda;
  logic [N_ATOMS-1:0]  r_mask;
  logic                r_busy;
  logic                r_done;

  logic                    w_start;
  logic signed [2*DW-1:0]  w_prod [LANES];
  logic [ACC_W-1:0]        w_word_sum;
  logic [ACC_W-1:0]        w_acc_next;
  logic [ACC_W-1:0]        w_abs;
  logic [ATOM_W-1:0]       w_cmp_atom;
  logic                    w_last_word;
  logic                    w_take;

  assign w_start = (r_state == ST_IDLE) && start_a;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    phi_addr     = '0;
    r_addr       = '0;
    case (r_state)
      ST_IDLE:  if (start_a) w_state_next = ST_RUN;
      ST_RUN: begin
        phi_addr = r_cnt;
        r_addr   = r_cnt[WORD_W-1:0];
        if (r_cnt == C_LAST_ADDR) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: w_state_next = ST_DONE;  // last word's data is consumed here
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_prod[k] = (2*DW)'($signed(phi_data[k*DW +: DW])) *
                       (2*DW)'($signed(r_data[k*DW +: DW]));
  end

  always_comb begin
    w_word_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_word_sum = w_word_sum + ACC_W'(w_prod[k]);
    end
  end

  // Word 0 restarts the accumulation instead of adding to the previous atom.
  assign w_acc_next  = ((r_tag1[WORD_W-1:0] == '0) ? '0 : r_acc) + w_word_sum;
  // ACC_W is wide enough that the most-negative value cannot occur.
  assign w_abs       = w_acc_next[ACC_W-1] ? (~w_acc_next + ACC_W'(1)) : w_acc_next;
  assign w_cmp_atom  = r_tag1[ADDR_W-1:WORD_W];
  assign w_last_word = (r_tag1[WORD_W-1:0] == C_LAST_WORD);
  // Strict '>' keeps the lower index on ties; the first unmasked atom is
  // always taken so that found reflects "some atom was available".
  assign w_take      = r_v1 && w_last_word && !r_mask[w_cmp_atom] &&
                       (!r_found || (w_abs > r_max));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_tag1   <= '0;
      r_acc    <= '0;
      r_max    <= '0;
      r_found  <= 1'b0;
      r_lambda <= '0;
      r_mask   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_v1   <= (r_state == ST_RUN);
      r_tag1 <= r_cnt;
      r_done <= (r_state == ST_DONE);

      if (w_start)                 r_cnt <= '0;
      else if (r_state == ST_RUN)  r_cnt <= r_cnt + ADDR_W'(1);

      if (r_v1) r_acc <= w_acc_next;

      if (w_start) begin
        r_max    <= '0;
        r_found  <= 1'b0;
        r_lambda <= '0;
      end else if (w_take) begin
        r_max    <= w_abs;
        r_found  <= 1'b1;
        r_lambda <= w_cmp_atom;
      end

      // A clear always beats the end-of-search mask set.
      if (sel_clr)                              r_mask           <= '0;
      else if ((r_state == ST_DONE) && r_found) r_mask[r_lambda] <= 1'b1;

      if (w_start)                  r_busy <= 1'b1;
      else if (r_state == ST_DONE)  r_busy <= 1'b0;
    end
  end

  assign busy_a     = r_busy;
  assign done_a     = r_done;
  assign found      = r_found;
  assign lambda_out = r_lambda;
`ifdef BLOCK_A_CORR_OUT_EN
  assign max_corr   = r_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_a_atom_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_a_atom_select
// Description : Scoreboard bench for block_a_atom_select. Directed searches
//               push their expected result; a negedge monitor pops and
//               compares on every done_a.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_a_atom_select;

  localparam int          LAT  = 515;
  localparam logic [55:0] FULL = 56'h8_0000_0000_0000;  // 32 * 2^46

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        sel_clr = 1'b0;
  logic [8:0]  phi_addr;
  logic [95:0] phi_data;
  logic [2:0]  r_addr;
  logic [95:0] r_data;
  logic        busy_a;
  logic        done_a;
  logic        found;
  logic [5:0]  lambda_out;
`ifdef BLOCK_A_CORR_OUT_EN
  logic [55:0] max_corr;
`endif

  logic [95:0] phi_mem [512];
  logic [95:0] r_mem   [8];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        f;
    logic [5:0]  l;
    logic [55:0] c;
    int          s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  block_a_atom_select dut (
    .clk        (clk),
    .rst        (rst),
    .start_a    (start_a),
    .sel_clr    (sel_clr),
    .phi_addr   (phi_addr),
    .phi_data   (phi_data),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .busy_a     (busy_a),
    .done_a     (done_a),
    .found      (found),
`ifdef BLOCK_A_CORR_OUT_EN
    .max_corr   (max_corr),
`endif
    .lambda_out (lambda_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency BRAM models
  always @(posedge clk) begin
    phi_data <= phi_mem[phi_addr];
    r_data   <= r_mem[r_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_a must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done_a=1 required=no done_a (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("latency", 64'(cyc - mon_e.s), 64'(LAT));
        check("found", 64'(found), 64'(mon_e.f));
        check("lambda_out", 64'(lambda_out), 64'(mon_e.l));
        check("busy_at_done", 64'(busy_a), 64'(0));
`ifdef BLOCK_A_CORR_OUT_EN
        check("max_corr", 64'(max_corr), 64'(mon_e.c));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) phi_mem[i] = '0;
    for (int i = 0; i < 8; i++)   r_mem[i]   = '0;
  endtask

  task automatic set_phi(input int atom, input int word, input int lane, input logic [23:0] v);
    phi_mem[atom*8 + word][lane*24 +: 24] = v;
  endtask

  task automatic set_r(input int word, input int lane, input logic [23:0] v);
    r_mem[word][lane*24 +: 24] = v;
  endtask

  task automatic pulse_clr();
    sel_clr = 1'b1;
    tick();
    sel_clr = 1'b0;
  endtask

  // Pulses start_a for one cycle; s is the cycle in which it was high.
  task automatic launch(input logic f, input logic [5:0] l, input logic [55:0] c,
                        input bit push, output int s);
    exp_t e;
    tick();
    s = cyc;
    if (push) begin
      e.f = f;
      e.l = l;
      e.c = c;
      e.s = s;
      sb.push_back(e);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 700 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no done_a required=done_a within %0d cycles", name, LAT);
      sb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic search(input logic f, input logic [5:0] l, input logic [55:0] c, input string name);
    int s;
    launch(f, l, c, 1'b1, s);
    wait_done(name);
  endtask

  initial begin
    int s;
    clear_mem();

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_found", 64'(found), 64'(0));
    check("rst_lambda", 64'(lambda_out), 64'(0));
    check("rst_phi_addr", 64'(phi_addr), 64'(0));
    check("rst_r_addr", 64'(r_addr), 64'(0));

    // ---- single strong atom: 1000 * 5 on atom 17
    set_phi(17, 0, 0, 24'd1000);
    set_r(0, 0, 24'd5);
    search(1'b1, 6'd17, 56'd5000, "single");

    // ---- tie at |500| between atoms 3 and 40 -> 3, then 40
    pulse_clr();
    clear_mem();
    set_phi(3, 2, 1, 24'd100);
    set_phi(40, 2, 1, 24'hFFFF9C);  // -100
    set_r(2, 1, 24'd5);
    search(1'b1, 6'd3, 56'd500, "tie_first");
    search(1'b1, 6'd40, 56'd500, "tie_second");

    // ---- magnitude: -2000 on atom 9 beats +1500 on atom 2
    pulse_clr();
    clear_mem();
    set_phi(9, 5, 3, 24'hFFFE70);   // -400
    set_phi(2, 5, 3, 24'd300);
    set_r(5, 3, 24'd5);
    search(1'b1, 6'd9, 56'd2000, "negative");

    // ---- full-scale: atoms 5 and 6 reach 2^51 (tie), atom 7 slightly less
    pulse_clr();
    clear_mem();
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) begin
        set_phi(5, w, k, 24'h800000);
        set_phi(6, w, k, 24'h800000);
        set_phi(7, w, k, 24'h7FFFFF);
        set_r(w, k, 24'h800000);
      end
    end
    search(1'b1, 6'd5, FULL, "full_scale");

    // ---- sel_clr in the DONE cycle beats the mask set of atom 6
    launch(1'b1, 6'd6, FULL, 1'b1, s);
    wait_until(s + 514);
    pulse_clr();
    wait_done("clr_at_done");
    search(1'b1, 6'd5, FULL, "clr_wins");

    // ---- sel_clr during RUN unmasks atom 5 before it is compared
    launch(1'b1, 6'd5, FULL, 1'b1, s);
    wait_until(s + 10);
    pulse_clr();
    wait_done("clr_in_run");

    // ---- start_a pulses while running are ignored
    pulse_clr();
    launch(1'b1, 6'd5, FULL, 1'b1, s);
    wait_until(s + 10);
    check("run_phi_addr", 64'(phi_addr), 64'(9));
    check("run_r_addr", 64'(r_addr), 64'(1));
    check("run_busy", 64'(busy_a), 64'(1));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_until(s + 300);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done("restart_ignored");

    // ---- reset mid-search: abort, outputs zero, mask (atom 5) cleared
    launch(1'b0, 6'd0, 56'd0, 1'b0, s);
    wait_until(s + 200);
    check("mid_phi_addr", 64'(phi_addr), 64'(199));
    check("mid_r_addr", 64'(r_addr), 64'(7));
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 64'(done_a), 64'(0));
    check("abort_busy", 64'(busy_a), 64'(0));
    check("abort_found", 64'(found), 64'(0));
    check("abort_lambda", 64'(lambda_out), 64'(0));
    check("abort_phi_addr", 64'(phi_addr), 64'(0));
`ifdef BLOCK_A_CORR_OUT_EN
    check("abort_max_corr", 64'(max_corr), 64'(0));
`endif
    tick();
    rst = 1'b0;
    repeat (600) tick();
    search(1'b1, 6'd5, FULL, "after_rst");

    // ---- exhaust the mask: all-zero Phi picks atoms in index order
    pulse_clr();
    clear_mem();
    for (int i = 0; i < 64; i++) search(1'b1, 6'(i), 56'd0, "exhaust");
    search(1'b0, 6'd0, 56'd0, "all_masked");
    pulse_clr();
    search(1'b1, 6'd0, 56'd0, "after_clr");

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
